// File: rtl/ring_inj_sched_pkg.sv
// Shared widths, lane state encodings and index helpers for the local
// injection scheduler.
package ring_inj_sched_pkg;

  // Router control-flit width and the position of its valid bit.
  localparam int CONTROL_W = 144;
  localparam int VLD_IDX   = 143;

  typedef enum logic {
    LANE_IDLE  = 1'b0,
    LANE_OFFER = 1'b1
  } lane_st_t;

  // Requester index k places after base, wrapped into 0..n-1.
  function automatic int rr_idx(input int base, input int k, input int n);
    int t;
    t = base + k;
    if (t >= n) t = t - n;
    return t;
  endfunction

endpackage

// File: rtl/ring_inj_sched_inj_fifo.sv
// Per-requester synchronous flit FIFO. Pointers and count are reset; the
// storage array is not, since its contents are only read when count > 0.
module ring_inj_sched_inj_fifo
  import ring_inj_sched_pkg::*;
#(
  parameter int FLIT_W = CONTROL_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_din,
  input  logic              i_pop,
  output logic [FLIT_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];

  // Storage write; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping, cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ring_inj_sched.sv
// Local injection scheduler: buffers flits from NREQ requesters and shares
// the two router injection lanes round-robin, keeping at most one flit per
// requester in flight so per-requester order is preserved.
module ring_inj_sched
  import ring_inj_sched_pkg::*;
#(
  parameter int FLIT_W   = CONTROL_W,
  parameter int NREQ     = 4,
  parameter int DEPTH    = 2,
  parameter int VLD_BIT  = VLD_IDX,
  parameter int STALL_TH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  output logic [NREQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]      portl0_ci,
  output logic [FLIT_W-1:0]      portl1_ci,
  input  logic                   portl0_ack,
  input  logic                   portl1_ack,
  output logic [1:0]             lane_stall
);

  localparam int       PW        = $clog2(NREQ);
  localparam logic [7:0] STALL_TH8 = 8'(STALL_TH);

  logic [FLIT_W-1:0] w_dout [NREQ];
  logic [NREQ-1:0]   w_full;
  logic [NREQ-1:0]   w_empty;
  logic [NREQ-1:0]   w_pop;
  logic [1:0]        w_ack;
  logic [1:0]        w_load;
  logic [1:0]        w_gv;
  logic [PW-1:0]     w_gid [2];
  logic [PW-1:0]     w_rr_nxt;

  lane_st_t          r_st   [2];
  logic [PW-1:0]     r_own  [2];
  logic [FLIT_W-1:0] r_ci   [2];
  logic [7:0]        r_wait [2];
  logic [PW-1:0]     r_rr;

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    ring_inj_sched_inj_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (req_valid[g]),
      .i_din   (req_flit[g*FLIT_W +: FLIT_W]),
      .i_pop   (w_pop[g]),
      .o_dout  (w_dout[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign req_ready  = ~w_full;
  assign w_ack      = {portl1_ack, portl0_ack};
  assign w_load[0]  = (r_st[0] == LANE_IDLE) | w_ack[0];
  assign w_load[1]  = (r_st[1] == LANE_IDLE) | w_ack[1];
  assign portl0_ci  = r_ci[0];
  assign portl1_ci  = r_ci[1];
  assign lane_stall = {(r_wait[1] >= STALL_TH8), (r_wait[0] >= STALL_TH8)};

  // Round-robin grant: lane 0 picks first, lane 1 skips lane 0's pick and
  // any requester whose flit is still being offered on the other lane.
  always_comb begin
    logic          v_gv0;
    logic          v_gv1;
    logic [PW-1:0] v_id0;
    logic [PW-1:0] v_id1;
    logic [PW-1:0] v_idx;
    v_gv0 = 1'b0;
    v_gv1 = 1'b0;
    v_id0 = '0;
    v_id1 = '0;
    v_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = PW'(rr_idx(int'(r_rr), k, NREQ));
      if (w_load[0] && !v_gv0 && !w_empty[v_idx] &&
          !(r_st[1] == LANE_OFFER && r_own[1] == v_idx)) begin
        v_gv0 = 1'b1;
        v_id0 = v_idx;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      v_idx = PW'(rr_idx(int'(r_rr), k, NREQ));
      if (w_load[1] && !v_gv1 && !w_empty[v_idx] &&
          !(r_st[0] == LANE_OFFER && r_own[0] == v_idx) &&
          !(v_gv0 && v_id0 == v_idx)) begin
        v_gv1 = 1'b1;
        v_id1 = v_idx;
      end
    end
    w_pop = '0;
    if (v_gv0) w_pop[v_id0] = 1'b1;
    if (v_gv1) w_pop[v_id1] = 1'b1;
    w_rr_nxt = r_rr;
    if (v_gv1)      w_rr_nxt = PW'(rr_idx(int'(v_id1), 1, NREQ));
    else if (v_gv0) w_rr_nxt = PW'(rr_idx(int'(v_id0), 1, NREQ));
    w_gv     = {v_gv1, v_gv0};
    w_gid[0] = v_id0;
    w_gid[1] = v_id1;
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rr <= '0;
    else      r_rr <= w_rr_nxt;
  end

  // Lane FSMs: load on grant, hold until ack, drop to idle with zero output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < 2; l++) begin
        r_st[l]   <= LANE_IDLE;
        r_own[l]  <= '0;
        r_ci[l]   <= '0;
        r_wait[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        case (r_st[l])
          LANE_IDLE: begin
            r_wait[l] <= '0;
            if (w_gv[l]) begin
              r_st[l]          <= LANE_OFFER;
              r_own[l]         <= w_gid[l];
              r_ci[l]          <= w_dout[w_gid[l]];
              r_ci[l][VLD_BIT] <= 1'b1;
            end
          end
          LANE_OFFER: begin
            if (w_ack[l]) begin
              r_wait[l] <= '0;
              if (w_gv[l]) begin
                r_own[l]         <= w_gid[l];
                r_ci[l]          <= w_dout[w_gid[l]];
                r_ci[l][VLD_BIT] <= 1'b1;
              end else begin
                r_st[l] <= LANE_IDLE;
                r_ci[l] <= '0;
              end
            end else if (r_wait[l] != 8'hff) begin
              r_wait[l] <= r_wait[l] + 8'd1;
            end
          end
          default: r_st[l] <= LANE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_inj_sched.sv
// Bench for ring_inj_sched: directed scenarios plus a per-requester
// scoreboard of accepted flits matched against flits the router consumes.
module tb_ring_inj_sched;

  localparam int FW = 144;
  localparam int NR = 4;
  localparam logic [FW-1:0] VLDM = {1'b1, 143'b0};
  localparam logic [FW-1:0] F1   = 144'h0aaaaaaaaaabcdef0123456789abcdef1857;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*FW-1:0]  req_flit = '0;
  logic [NR-1:0]     req_ready;
  logic [FW-1:0]     portl0_ci;
  logic [FW-1:0]     portl1_ci;
  logic              portl0_ack = 1'b0;
  logic              portl1_ack = 1'b0;
  logic [1:0]        lane_stall;

  int n_chk = 0;
  int n_err = 0;
  logic [FW-1:0] sbq [NR][$];

  ring_inj_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_flit   (req_flit),
    .req_ready  (req_ready),
    .portl0_ci  (portl0_ci),
    .portl1_ci  (portl1_ci),
    .portl0_ack (portl0_ack),
    .portl1_ack (portl1_ack),
    .lane_stall (lane_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mkflit(input int id, input int seq);
    logic [FW-1:0] f;
    f = '0;
    f[139:136] = 4'(id);
    f[31:0] = 32'(seq);
    return f;
  endfunction

  function automatic int idof(input logic [FW-1:0] f);
    return int'(f[139:136]);
  endfunction

  // Consumed flit must be at the head of exactly one requester's queue.
  task automatic sb_take(input string tag, input logic [FW-1:0] got);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!found && sbq[i].size() != 0 && sbq[i][0] == got) begin
        void'(sbq[i].pop_front());
        found = 1'b1;
      end
    end
    if (!found) $display("unmatched flit on %s: %h", tag, got);
    chk(tag, FW'(found), FW'(1));
  endtask

  task automatic apply_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) sbq[i].delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) sbq[i].push_back(req_flit[i*FW +: FW] | VLDM);
      if (portl0_ack && portl0_ci != '0) sb_take("sb_lane0", portl0_ci);
      if (portl1_ack && portl1_ci != '0) sb_take("sb_lane1", portl1_ci);
    end
  end

  initial begin
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic [NR-1:0] seen;
    int acc;
    int n;
    logic acc_done;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ci0", portl0_ci, '0);
    chk("rst_ci1", portl1_ci, '0);
    chk("rst_stall", FW'(lane_stall), '0);
    chk("rst_ready", FW'(req_ready), FW'(4'hf));
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Single flit from requester 2
    req_valid = 4'b0100;
    req_flit[2*FW +: FW] = F1;
    tick();
    req_valid = '0;
    chk("single_early", portl0_ci, '0);
    tick();
    chk("single_ci0", portl0_ci, F1 | VLDM);
    chk("single_ci1", portl1_ci, '0);
    portl0_ack = 1'b1;
    tick();
    portl0_ack = 1'b0;
    chk("single_done", portl0_ci, '0);

    // Ordering: A then B from requester 0
    fa = mkflit(0, 16'hA0A);
    fb = mkflit(0, 16'hB0B);
    req_valid = 4'b0001;
    req_flit[0 +: FW] = fa;
    tick();
    req_flit[0 +: FW] = fb;
    tick();
    req_valid = '0;
    chk("ord_a0", portl0_ci, fa | VLDM);
    chk("ord_l1_0", portl1_ci, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ord_hold_a", portl0_ci, fa | VLDM);
      chk("ord_l1_hold", portl1_ci, '0);
    end
    portl0_ack = 1'b1;
    tick();
    chk("ord_b0", portl0_ci, fb | VLDM);
    chk("ord_l1_b", portl1_ci, '0);
    tick();
    portl0_ack = 1'b0;
    chk("ord_idle", portl0_ci, '0);

    // Fairness from a fresh round-robin pointer
    apply_reset();
    portl0_ack = 1'b1;
    portl1_ack = 1'b1;
    req_valid = 4'hf;
    seen = '0;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NR; i++) req_flit[i*FW +: FW] = mkflit(i, 100 + c);
      tick();
      if (c >= 1) begin
        chk("fair_l0", FW'(idof(portl0_ci)), FW'(((c - 1) % 2 == 0) ? 0 : 2));
        chk("fair_l1", FW'(idof(portl1_ci)), FW'(((c - 1) % 2 == 0) ? 1 : 3));
        chk("fair_vld0", FW'(portl0_ci[143]), FW'(1));
        seen[idof(portl0_ci) % NR] = 1'b1;
        seen[idof(portl1_ci) % NR] = 1'b1;
      end
    end
    chk("fair_seen", FW'(seen), FW'(4'hf));
    req_valid = '0;
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < NR; i++) chk("drain_q", FW'(sbq[i].size()), '0);
    chk("drain_ci0", portl0_ci, '0);
    chk("drain_ci1", portl1_ci, '0);
    portl0_ack = 1'b0;
    portl1_ack = 1'b0;
    tick();

    // Back-pressure and stall detection on lane 0
    acc = 0;
    n = -1;
    acc_done = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 90 && n < 64; c++) begin
      req_flit[1*FW +: FW] = mkflit(1, 200 + c);
      if (req_valid[1] && req_ready[1]) acc++;
      tick();
      if (n < 0 && portl0_ci != '0) n = 0;
      else if (n >= 0) n++;
      if (!acc_done && !req_ready[1]) begin
        acc_done = 1'b1;
        req_valid = '0;
        chk("bp_accepted", FW'(acc), FW'(1 + 2));
      end
      if (n == 63) chk("stall_63", FW'(lane_stall[0]), '0);
      if (n == 64) chk("stall_64", FW'(lane_stall[0]), FW'(1));
    end
    req_valid = '0;
    chk("stall_reached", FW'(n), FW'(64));
    chk("stall_l1", FW'(lane_stall[1]), '0);
    chk("bp_l1_idle", portl1_ci, '0);
    portl0_ack = 1'b1;
    tick();
    portl0_ack = 1'b0;
    chk("stall_clear", FW'(lane_stall[0]), '0);
    chk("bp_reload_id", FW'(idof(portl0_ci)), FW'(1));

    // Async reset while both lanes offer
    fa = mkflit(3, 16'h333);
    req_valid = 4'b1000;
    req_flit[3*FW +: FW] = fa;
    tick();
    req_valid = '0;
    tick();
    chk("ar_l1_loaded", portl1_ci, fa | VLDM);
    chk("ar_l0_busy", FW'(portl0_ci != '0), FW'(1));
    #2 rst = 1'b0;
    #1;
    chk("ar_ci0", portl0_ci, '0);
    chk("ar_ci1", portl1_ci, '0);
    chk("ar_ready", FW'(req_ready), FW'(4'hf));
    chk("ar_stall", FW'(lane_stall), '0);
    for (int i = 0; i < NR; i++) sbq[i].delete();
    @(posedge clk);
    #3 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ar_stale0", portl0_ci, '0);
      chk("ar_stale1", portl1_ci, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ring_inj_sched.md
# ring_inj_sched

Local injection scheduler for a hierarchical-ring `nodeRouter`. It buffers flits from up to `NREQ` local requesters (core, cache, and memory-controller queues) and shares the router's two local injection ports among them. Each port is `portl0_ci`/`portl1_ci`, acknowledged by `portl0_ack`/`portl1_ack`. Arbitration is round-robin, and per-requester flit ordering is preserved. It sits directly between the node's local agents and `nodeRouter`.

## Interface
Parameters:
- `FLIT_W`, default 144: flit width; equals the `` `control_w `` width.
- `NREQ`, default 4: number of requesters (2..8).
- `DEPTH`, default 2: per-requester FIFO depth (power of two, ≥2).
- `VLD_BIT`, default 143: index of the flit valid bit.
- `STALL_TH`, default 64: wait cycles before a lane is flagged stalled.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  **asynchronous, active-low** reset.
- `req_valid`  in  `NREQ`  per-requester flit-offer strobe.
- `req_flit`  in  `NREQ*FLIT_W`  requester i occupies bits `[i*FLIT_W +: FLIT_W]`.
- `req_ready`  out  `NREQ`  FIFO i not full.
- `portl0_ci`  out  `FLIT_W`  lane-0 flit to the router; all-zero when idle.
- `portl1_ci`  out  `FLIT_W`  lane-1 flit to the router; all-zero when idle.
- `portl0_ack`  in  1  router consumed the lane-0 flit this cycle.
- `portl1_ack`  in  1  router consumed the lane-1 flit this cycle.
- `lane_stall`  out  2  lane L has waited at least `STALL_TH` cycles without an ack.

## Operation
- **Enqueue.** Requester i transfers a flit on `req_valid[i] & req_ready[i]`.
  - `req_ready[i] = !full_i` is taken from the registered count only; there is no bypass.
  - A simultaneous enqueue and dequeue on a full FIFO is therefore impossible. On a non-full FIFO, the count is unchanged.
- **Lanes.** Each lane L∈{0,1} has a holding register, an owner id, and a two-state FSM.
  - IDLE: `portlL_ci` = 0.
  - OFFER: `portlL_ci` = held flit with bit `VLD_BIT` forced to 1.
  - IDLE→OFFER when the lane is loaded.
  - OFFER→OFFER (reload) when `portlL_ack` = 1 and an eligible FIFO exists.
  - OFFER→IDLE when `portlL_ack` = 1 and no eligible FIFO exists.
  - OFFER holds while `portlL_ack` = 0.
- **Eligibility.** Requester i is eligible for lane L when all of the following hold:
  - its FIFO is non-empty;
  - the other lane is not in OFFER with owner i (ordering rule: at most one in-flight flit per requester);
  - it is not being granted to the other lane in the same cycle.
- **Arbitration.** Lanes are evaluated in order: lane 0 first, then lane 1.
  - Each lane picks the first eligible requester at or after `rr_ptr` (mod `NREQ`).
  - `rr_ptr` ← (last requester granted this cycle) + 1, where lane 1's grant wins if both lanes grant.
  - `rr_ptr` is unchanged if nothing is granted.
- **Ack on an IDLE lane** is ignored; no state change.
- **Stall counter.** Each lane has an 8-bit saturating wait counter.
  - It increments each cycle in OFFER with ack = 0, and clears on ack or in IDLE.
  - `lane_stall[L]` = (counter ≥ `STALL_TH`).

## Timing
- **Reset values:** `portl0_ci` = `portl1_ci` = 0, `lane_stall` = 0, `req_ready` = all ones, FIFOs empty, lanes IDLE, `rr_ptr` = 0.
- **Reset mid-operation** discards all buffered and held flits immediately (asynchronous). Ports go to zero without waiting for the clock.
- **Latency:** a flit enqueued at edge k is dequeued at edge k+1 (lane IDLE, no contention) and appears on `portlL_ci` after edge k+1. Minimum latency is 1 cycle from handshake to offer.
- **Acks** are sampled at the rising edge. Ack and reload on the same edge gives back-to-back flits with no bubble.
- **Outputs:** `portlL_ci` and `lane_stall` are register outputs only. `req_ready` depends on registered count only.

## Structure
- The shared defines header (`defines.v`) holds the `` `control_w `` width macro, the valid-bit index macro (the default for `VLD_BIT`), and the IDLE/OFFER state encodings.
- One sub-module is natural: `inj_fifo`, a parameterised synchronous FIFO (`FLIT_W`, `DEPTH`) with full/empty/count, instantiated `NREQ` times via generate.
- Arbitration and the lane FSMs stay in the top level.

## Test plan
- **Single flit:** reset, then requester 2 offers `144'h0aaaaaaaaaabcdef0123456789abcdef1857` for one cycle. Required: lane 0 drives it with bit 143 set one cycle later; ack on the next edge → `portl0_ci` = 0.
- **Ordering:** requester 0 enqueues A then B back-to-back. Required: B is never offered on lane 1 while A is held on lane 0; B appears on lane 0 the cycle after A is acked.
- **Fairness:** all 4 requesters continuously valid, both acks tied high. Required: grant order per cycle (0,1), (2,3), (0,1); no requester skipped over 8 cycles.
- **Back-pressure:** acks held 0 and requester 1 streams flits. Required: `req_ready[1]` drops after 1 held flit + `DEPTH` buffered flits; `lane_stall[0]` rises at wait cycle 64; releasing ack clears it the next cycle.
- **Async reset mid-stream:** assert `rst` = 0 between clock edges while both lanes are in OFFER. Required: both `ci` = 0 and `req_ready` = all ones immediately; no stale flit after release.
